// File: rtl/dcache_port_arbiter_pkg.sv
// Shared widths, starvation threshold and FSM state encoding for the D$ port arbiter.
// Imported by the interface, the picker and the top.
package dcache_port_arbiter_pkg;

    localparam int ARB_INDEX_W      = 19;
    localparam int ARB_DATA_W       = 64;
    localparam int ARB_STORE_STARVE = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// LSU load/store channels plus the single D$ request/response port.
// master = arbiter view, slave = LSU/D$ environment view.
interface dcache_port_arbiter_if
    import dcache_port_arbiter_pkg::*;
#(
    parameter int INDEX_W = ARB_INDEX_W,
    parameter int DATA_W  = ARB_DATA_W
);
    logic               opload_index_valid;
    logic [INDEX_W-1:0] opload_index;
    logic               opload_index_ready;
    logic [DATA_W-1:0]  opload_read_data;
    logic               opload_operation_done;

    logic               opstore_index_valid;
    logic [INDEX_W-1:0] opstore_index;
    logic [DATA_W-1:0]  opstore_write_data;
    logic [DATA_W-1:0]  opstore_write_mask;
    logic               opstore_index_ready;
    logic               opstore_operation_done;

    logic               mem_req_valid;
    logic               mem_req_ready;
    logic               mem_req_is_write;
    logic [INDEX_W-1:0] mem_req_index;
    logic [DATA_W-1:0]  mem_req_wdata;
    logic [DATA_W-1:0]  mem_req_wmask;
    logic               mem_resp_valid;
    logic [DATA_W-1:0]  mem_resp_rdata;

    modport master (
        input  opload_index_valid, opload_index,
        output opload_index_ready, opload_read_data, opload_operation_done,
        input  opstore_index_valid, opstore_index, opstore_write_data, opstore_write_mask,
        output opstore_index_ready, opstore_operation_done,
        output mem_req_valid, mem_req_is_write, mem_req_index, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        output opload_index_valid, opload_index,
        input  opload_index_ready, opload_read_data, opload_operation_done,
        output opstore_index_valid, opstore_index, opstore_write_data, opstore_write_mask,
        input  opstore_index_ready, opstore_operation_done,
        input  mem_req_valid, mem_req_is_write, mem_req_index, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

endinterface

// File: rtl/dcache_port_arbiter_pick.sv
// Two-way load/store picker: load wins unless the store is alone or promoted.
// Purely combinational, zero latency; grants only go to a valid requester.
module mem_arb_pick (
    input  logic i_load_v,
    input  logic i_store_v,
    input  logic i_promote,
    output logic o_grant_load,
    output logic o_grant_store
);

    assign o_grant_store = i_store_v & (i_promote | ~i_load_v);
    assign o_grant_load  = i_load_v & ~o_grant_store;

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares one D$ port between LSU load and store channels, one op outstanding, store starvation guard.
// Accept T, mem_req T+1, done T+3 at best; holds request fields while mem_req_ready is low.
module dcache_port_arbiter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int INDEX_W      = ARB_INDEX_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int STORE_STARVE = ARB_STORE_STARVE
)(
    input  logic                  clock,
    input  logic                  reset_n,
    dcache_port_arbiter_if.master bus,
    output logic                  arb_busy
);

    localparam int CNT_W = $clog2(STORE_STARVE + 1);

    arb_state_t         r_state;
    arb_state_t         w_next_state;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic [INDEX_W-1:0] r_index;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_wmask;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_is_write;

    logic w_promote;
    logic w_grant_load;
    logic w_grant_store;
    logic w_idle;

    assign w_idle    = (r_state == ARB_IDLE);
    assign w_promote = (r_starve_cnt == CNT_W'(STORE_STARVE));

    mem_arb_pick u_pick (
        .i_load_v      (bus.opload_index_valid),
        .i_store_v     (bus.opstore_index_valid),
        .i_promote     (w_promote),
        .o_grant_load  (w_grant_load),
        .o_grant_store (w_grant_store)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Ready is only raised towards a valid requester, so a grant is always an accept.
    always_comb begin
        w_next_state               = r_state;
        bus.opload_index_ready     = 1'b0;
        bus.opstore_index_ready    = 1'b0;
        bus.mem_req_valid          = 1'b0;
        bus.opload_operation_done  = 1'b0;
        bus.opstore_operation_done = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                bus.opload_index_ready  = w_grant_load;
                bus.opstore_index_ready = w_grant_store;
                if (w_grant_load || w_grant_store) begin
                    w_next_state = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    w_next_state = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (bus.mem_resp_valid) begin
                    w_next_state = ARB_DONE;
                end
            end
            ARB_DONE: begin
                bus.opload_operation_done  = ~r_is_write;
                bus.opstore_operation_done = r_is_write;
                w_next_state               = ARB_IDLE;
            end
            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
            r_index      <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_rdata      <= '0;
            r_is_write   <= 1'b0;
        end else begin
            if (w_idle && w_grant_store) begin
                r_index      <= bus.opstore_index;
                r_wdata      <= bus.opstore_write_data;
                r_wmask      <= bus.opstore_write_mask;
                r_is_write   <= 1'b1;
                r_starve_cnt <= '0;
            end else if (w_idle && w_grant_load) begin
                r_index    <= bus.opload_index;
                r_wdata    <= '0;
                r_wmask    <= '0;
                r_is_write <= 1'b0;
                if (bus.opstore_index_valid && !w_promote) begin
                    r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                end
            end
            if (r_state == ARB_WAIT && bus.mem_resp_valid && !r_is_write) begin
                r_rdata <= bus.mem_resp_rdata;
            end
        end
    end

    assign bus.mem_req_is_write = r_is_write;
    assign bus.mem_req_index    = r_index;
    assign bus.mem_req_wdata    = r_wdata;
    assign bus.mem_req_wmask    = r_wmask;
    assign bus.opload_read_data = r_rdata;
    assign arb_busy             = !w_idle;

    // A response with nothing outstanding means the D$ broke protocol.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            assert (!(bus.mem_resp_valid && r_state != ARB_WAIT));
            assert (!(bus.opload_index_ready && bus.opstore_index_ready));
        end
    end

endmodule
